pattern_generator: RTL and testbench
====================================

PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of pattern words and of data_out.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of pattern memory entries; ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the pattern memory write strobe.
REQ-007 wr_addr  input  ADDR_W  SHALL be the pattern memory write address.
REQ-008 wr_data  input  DATA_WIDTH  SHALL be the pattern memory write data.
REQ-009 start  input  1  SHALL be a single-cycle request to begin playback.
REQ-010 stop  input  1  SHALL be a single-cycle request to abort playback.
REQ-011 len  input  ADDR_W+1  SHALL give the number of entries to play, 1..DEPTH.
REQ-012 div  input  16  SHALL give the hold time per entry minus one, in clk cycles.
REQ-013 loop_en  input  1  SHALL select continuous wrap-around playback.
REQ-014 data_out  output  DATA_WIDTH  SHALL be the registered pattern output to the probe pins.
REQ-015 busy  output  1  SHALL be high while in RUN.
REQ-016 done  output  1  SHALL pulse high for one cycle on normal completion.

Function
REQ-017 States SHALL be IDLE and RUN only.
REQ-018 In IDLE, wr_en SHALL write wr_data to mem[wr_addr] at the clock edge; writes while busy=1 SHALL be ignored.
REQ-019 In IDLE, start=1 with len!=0 and stop=0 SHALL latch len, div, loop_en, set address 0, and enter RUN.
REQ-020 start with len=0, start while busy, or start and stop together in IDLE SHALL be ignored.
REQ-021 len greater than DEPTH SHALL be clamped to DEPTH at latch time.
REQ-022 Changes to len/div/loop_en during RUN SHALL have no effect until the next start.
REQ-023 For start sampled at edge T, data_out SHALL equal mem[k] from edge T+1+k*(div+1) for div+1 cycles, k = 0..len-1; busy SHALL rise at edge T+1.
REQ-024 At edge T+1+len*(div+1) with loop_en=0: busy SHALL fall, done SHALL be 1 for exactly one cycle, data_out SHALL hold mem[len-1].
REQ-025 At that edge with loop_en=1: address SHALL wrap to 0, data_out SHALL become mem[0], busy SHALL stay 1, done SHALL stay 0.
REQ-026 Hold counter SHALL be 16-bit; div=0 SHALL advance one entry per cycle; div=16'hFFFF SHALL hold 65536 cycles.
REQ-027 stop=1 in RUN SHALL return to IDLE at the next edge, busy=0, done=0, data_out holding its current value.
REQ-028 stop in IDLE SHALL have no effect.
REQ-029 data_out SHALL change only at entry boundaries; no glitches between boundaries.

Reset
REQ-030 With rst=1 at an edge: state=IDLE, data_out=0, busy=0, done=0, counters=0.
REQ-031 Reset SHALL take priority over start, stop and wr_en in the same cycle.
REQ-032 Pattern memory SHALL NOT be cleared by reset.
REQ-033 Reset mid-RUN SHALL abort playback with no done pulse.

Verification
REQ-034 Load AA,55,F0,0F at 0..3; len=4, div=2, loop_en=0; start at T -> data_out AA@T+1, 55@T+4, F0@T+7, 0F@T+10; done=1 only at T+13; busy 0 at T+13; data_out stays 0F.
REQ-035 Same memory, len=2, div=0, loop_en=1 -> data_out AA,55,AA,55... each cycle; done never asserts; stop at T+5 -> busy=0 at T+6, data_out frozen.
REQ-036 wr_en to addr 0 with 8'h11 while busy -> mem[0] unchanged; next playback shows AA at k=0.
REQ-037 start with len=0 -> busy stays 0, data_out unchanged; len=31 with DEPTH=16 -> 16 entries played then done.
REQ-038 rst=1 at T+5 of REQ-034 run -> data_out=00, busy=0, done=0 next cycle; restart replays AA,55,F0,0F.
REQ-039 start and stop together in IDLE -> stays IDLE; start together with rst -> IDLE, outputs 0.

Source files
------------

// File: rtl/pattern_generator_if.sv
// Bus bundle for the pattern generator: pattern-memory write port, playback
// control, and the probe-pin outputs.
interface pattern_generator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic                  stop;
  logic [ADDR_W:0]       len;
  logic [15:0]           div;
  logic                  loop_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, len, div, loop_en,
    input  data_out, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, len, div, loop_en,
    output data_out, busy, done
  );
endinterface

// File: rtl/pattern_generator.sv
// Pattern generator: plays back len words from a small pattern memory,
// holding each word div+1 cycles, once or in a continuous loop.
module pattern_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic               clk,
  input  logic               rst,
  pattern_generator_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [ADDR_W-1:0]     last_r;
  logic [15:0]           hold_r;
  logic [15:0]           div_r;
  logic                  loop_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  busy_r;
  logic                  done_r;

  logic [ADDR_W:0]       len_clamp_s;
  logic [ADDR_W-1:0]     last_s;
  logic [ADDR_W-1:0]     addr_nxt_s;
  logic                  start_ok_s;
  logic                  wr_ok_s;
  logic                  boundary_s;
  logic                  at_last_s;

  // Launch qualification, length clamp and playback position decode.
  always_comb begin
    len_clamp_s = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    last_s      = ADDR_W'(len_clamp_s - LEN_ONE);
    addr_nxt_s  = addr_r + ADDR_ONE;
    start_ok_s  = bus.start & ~bus.stop & (bus.len != LEN_ZERO);
    // Memory is frozen during playback so the sequence cannot change under it.
    wr_ok_s     = ~rst & bus.wr_en & (state_r == IDLE) &
                  ({1'b0, bus.wr_addr} < DEPTH_L);
    boundary_s  = (hold_r == div_r);
    at_last_s   = (addr_r == last_r);
  end

  // Pattern memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Playback FSM with registered probe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= ADDR_ZERO;
      last_r  <= ADDR_ZERO;
      hold_r  <= 16'h0000;
      div_r   <= 16'h0000;
      loop_r  <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            addr_r  <= ADDR_ZERO;
            hold_r  <= 16'h0000;
            last_r  <= last_s;
            div_r   <= bus.div;
            loop_r  <= bus.loop_en;
            data_r  <= mem_r[ADDR_ZERO];
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (boundary_s) begin
            hold_r <= 16'h0000;
            if (!at_last_s) begin
              addr_r <= addr_nxt_s;
              data_r <= mem_r[addr_nxt_s];
            end else if (loop_r) begin
              addr_r <= ADDR_ZERO;
              data_r <= mem_r[ADDR_ZERO];
            end else begin
              // Last word stays on the pins after normal completion.
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            hold_r <= hold_r + 16'h0001;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: single-shot, looped, aborted,
// clamped and reset-interrupted playback with hand-computed expectations.
module tb_pattern_generator;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_mem [16];

  pattern_generator_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  pattern_generator #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Drives a one-cycle start; returns just after the edge that launched playback.
  task automatic launch(input int l, input int dv, input logic lp);
    bus.len     = 5'(l);
    bus.div     = 16'(dv);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  initial begin
    exp_mem[0] = 8'hAA;
    exp_mem[1] = 8'h55;
    exp_mem[2] = 8'hF0;
    exp_mem[3] = 8'h0F;
    for (int i = 4; i < 16; i++) exp_mem[i] = 8'(8'h30 + i);

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h00;
    bus.start = 1'b0; bus.stop = 1'b0; bus.len = 5'd0;
    bus.div = 16'd0; bus.loop_en = 1'b0;
    step();
    step();
    chk("reset_data", bus.data_out, 8'h00);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);

    // start together with reset stays idle
    bus.len = 5'd4; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 1'b0);
    chk("rst_start_data", bus.data_out, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) wr(i, exp_mem[i]);

    // single shot, div=2; parameter changes mid-run must be ignored
    launch(4, 2, 1'b0);
    bus.len = 5'd1; bus.div = 16'd0; bus.loop_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      chk("t1_data", bus.data_out, exp_mem[(c-1)/3]);
      chk("t1_busy", bus.busy, 1'b1);
      chk("t1_done", bus.done, 1'b0);
      step();
    end
    chk("t1_end_done", bus.done, 1'b1);
    chk("t1_end_busy", bus.busy, 1'b0);
    chk("t1_end_data", bus.data_out, 8'h0F);
    step();
    chk("t1_post_done", bus.done, 1'b0);
    chk("t1_post_data", bus.data_out, 8'h0F);

    // stop in idle does nothing
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("idle_stop_busy", bus.busy, 1'b0);
    chk("idle_stop_data", bus.data_out, 8'h0F);

    // looped playback, div=0, then abort
    launch(2, 0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      chk("t2_data", bus.data_out, exp_mem[(c-1)%2]);
      chk("t2_busy", bus.busy, 1'b1);
      chk("t2_done", bus.done, 1'b0);
      if (c < 5) step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t2_stop_busy", bus.busy, 1'b0);
    chk("t2_stop_done", bus.done, 1'b0);
    chk("t2_stop_data", bus.data_out, 8'hAA);
    step();
    chk("t2_frozen_data", bus.data_out, 8'hAA);
    chk("t2_frozen_done", bus.done, 1'b0);

    // write while busy is ignored
    launch(4, 0, 1'b0);
    chk("t3_k0", bus.data_out, 8'hAA);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h11;
    step();
    bus.wr_en = 1'b0;
    chk("t3_k1", bus.data_out, 8'h55);
    step();
    step();
    chk("t3_k3", bus.data_out, 8'h0F);
    step();
    chk("t3_done", bus.done, 1'b1);
    chk("t3_busy", bus.busy, 1'b0);
    launch(1, 0, 1'b0);
    chk("t3_replay_k0", bus.data_out, 8'hAA);
    chk("t3_replay_busy", bus.busy, 1'b1);
    step();
    chk("t3_len1_done", bus.done, 1'b1);
    chk("t3_len1_data", bus.data_out, 8'hAA);

    // len=0 ignored
    bus.len = 5'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("len0_busy", bus.busy, 1'b0);
    chk("len0_data", bus.data_out, 8'hAA);
    chk("len0_done", bus.done, 1'b0);

    // len=31 clamps to 16 entries
    launch(31, 0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      chk("clamp_data", bus.data_out, exp_mem[c-1]);
      chk("clamp_busy", bus.busy, 1'b1);
      step();
    end
    chk("clamp_done", bus.done, 1'b1);
    chk("clamp_busy_end", bus.busy, 1'b0);
    chk("clamp_data_end", bus.data_out, exp_mem[15]);

    // reset mid-run, with a write in the same cycle that must be dropped
    launch(4, 2, 1'b0);
    for (int c = 1; c < 5; c++) step();
    chk("t5_pre_rst_data", bus.data_out, 8'h55);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'h77;
    step();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    chk("t5_rst_data", bus.data_out, 8'h00);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_done", bus.done, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t5_no_done", bus.done, 1'b0);
    end
    launch(4, 2, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      chk("t5_replay_data", bus.data_out, exp_mem[(c-1)/3]);
      chk("t5_replay_done", bus.done, 1'b0);
      step();
    end
    chk("t5_replay_end", bus.done, 1'b1);

    // start and stop together in idle
    bus.len = 5'd4; bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("ss_busy", bus.busy, 1'b0);
    chk("ss_data", bus.data_out, 8'h0F);
    step();
    chk("ss_busy2", bus.busy, 1'b0);

    // maximum hold: div=FFFF holds one entry for 65536 cycles
    launch(1, 16'hFFFF, 1'b0);
    chk("maxdiv_data", bus.data_out, 8'hAA);
    for (int c = 1; c < 65536; c++) step();
    chk("maxdiv_busy_last", bus.busy, 1'b1);
    chk("maxdiv_done_last", bus.done, 1'b0);
    step();
    chk("maxdiv_done", bus.done, 1'b1);
    chk("maxdiv_busy_end", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
